// File: rtl/pll_supervisor_pkg.sv
// Shared clock package: PLL supervisor state encoding, default timing
// constants and the state-to-output decode reused by other PLL wrappers.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } pll_state_e;

  // Default timing for a 12 MHz reference clock.
  localparam int unsigned DEF_HOLD_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 12000;  // 1 ms
  localparam int unsigned DEF_SETTLE_CYCLES = 1200;
  localparam int unsigned DEF_MAX_RETRIES   = 4;

  localparam int unsigned LOSS_W      = 8;
  localparam int unsigned RETRY_OUT_W = 4;

  // Registered control outputs, decoded from the state being entered.
  typedef struct packed {
    logic pll_resetb;
    logic domain_reset;
    logic ready;
    logic fault;
  } pll_outs_t;

  function automatic pll_outs_t state_outputs(input pll_state_e s);
    pll_outs_t o;
    o.pll_resetb   = (s == ST_WAIT_LOCK) || (s == ST_SETTLE) || (s == ST_RUN);
    o.domain_reset = (s != ST_RUN);
    o.ready        = (s == ST_RUN);
    o.fault        = (s == ST_FAULT);
    return o;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk_i domain.
module sync_2ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for lock, requires a
// stable settle window before releasing the pixel domain, retries on failure
// and watches for lock loss while running.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       pll_lock_i,
  output logic       pll_resetb_o,
  output logic       domain_reset_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_count_o,
  output logic [7:0] loss_count_o
);

  // The cycle counter only ever needs to reach (longest window - 1).
  localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [RETRY_W-1:0]  retry_inc;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                low_q, low_d;
  logic                fail;
  pll_outs_t           outs_q;

  sync_2ff u_lock_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (pll_lock_i),
    .q_o     (lock_s)
  );

  assign retry_inc = retry_q + 1'b1;

  // Next-state logic: sequencing, failure handling and lock-loss filtering.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    low_d   = 1'b0;
    fail    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + 1'b1;
        if (lock_s)                  state_d = ST_SETTLE;
        else if (cnt_q == LOCK_LAST) fail = 1'b1;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        // One low sample is remembered; a second consecutive one is a loss.
        if (!lock_s) begin
          if (low_q) begin
            state_d = ST_HOLD;
            loss_d  = (loss_q == {LOSS_W{1'b1}}) ? loss_q : loss_q + 1'b1;
          end else begin
            low_d = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_HOLD;
    end

    // Dropping ENABLE wins over every transition above.
    if (!enable_i) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end

    // Every state entry starts its window from zero.
    if (state_d != state_q) cnt_d = '0;
    if (state_d != ST_RUN)  low_d = 1'b0;
  end

  // State, counters and outputs; outputs are decoded from the state being entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      low_q   <= 1'b0;
      outs_q  <= state_outputs(ST_IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      low_q   <= low_d;
      outs_q  <= state_outputs(state_d);
    end
  end

  assign pll_resetb_o   = outs_q.pll_resetb;
  assign domain_reset_o = outs_q.domain_reset;
  assign ready_o        = outs_q.ready;
  assign fault_o        = outs_q.fault;
  assign retry_count_o  = RETRY_OUT_W'(retry_q);
  assign loss_count_o   = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with a scoreboard of expected output snapshots.
module tb_pll_supervisor;

  localparam int HC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pll_lock;
  logic       pll_resetb;
  logic       domain_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rb;
    logic       dr;
    logic       rdy;
    logic       flt;
    logic [3:0] retry;
    logic [7:0] loss;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  pll_supervisor #(
    .HOLD_CYCLES   (HC),
    .LOCK_TIMEOUT  (LT),
    .SETTLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .pll_lock_i     (pll_lock),
    .pll_resetb_o   (pll_resetb),
    .domain_reset_o (domain_reset),
    .ready_o        (ready),
    .fault_o        (fault),
    .retry_count_o  (retry_count),
    .loss_count_o   (loss_count)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp(input string t, input string f, input logic [7:0] got,
                     input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s got=%0h want=%0h", t, f, got, want);
    end
  endtask

  task automatic push_exp(input string t, input logic rb, input logic dr, input logic rdy,
                          input logic flt, input logic [3:0] r, input logic [7:0] l);
    exp_t e;
    e.rb = rb; e.dr = dr; e.rdy = rdy; e.flt = flt; e.retry = r; e.loss = l;
    sb_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=0 want=1");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "pll_resetb",   8'(pll_resetb),   8'(e.rb));
      cmp(t, "domain_reset", 8'(domain_reset), 8'(e.dr));
      cmp(t, "ready",        8'(ready),        8'(e.rdy));
      cmp(t, "fault",        8'(fault),        8'(e.flt));
      cmp(t, "retry_count",  8'(retry_count),  8'(e.retry));
      cmp(t, "loss_count",   loss_count,       e.loss);
    end
  endtask

  // Expect a snapshot, advance n cycles, then compare it.
  task automatic step(input string t, input int n, input logic rb, input logic dr,
                      input logic rdy, input logic flt, input logic [3:0] r,
                      input logic [7:0] l);
    push_exp(t, rb, dr, rdy, flt, r, l);
    tick(n);
    check_out();
    $display("txn %-14s rb=%0b dr=%0b rdy=%0b flt=%0b retry=%0d loss=%0d",
             t, pll_resetb, domain_reset, ready, fault, retry_count, loss_count);
  endtask

  task automatic wait_ready(input string t);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    cmp(t, "ready_within_bound", 8'(ready), 8'd1);
  endtask

  initial begin
    logic [7:0] exp_loss;

    reset = 1'b1; enable = 1'b0; pll_lock = 1'b0;
    step("reset", 3, 0, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("idle_hold", 3, 0, 1, 0, 0, 0, 0);

    // Normal bring-up: lock ten cycles after PLL_RESETB rises.
    enable = 1'b1;
    step("hold_len", 4, 0, 1, 0, 0, 0, 0);
    step("wait_entry", 1, 1, 1, 0, 0, 0, 0);
    tick(10);
    pll_lock = 1'b1;
    step("settling", 10, 1, 1, 0, 0, 0, 0);
    step("run_entry", 1, 1, 0, 1, 0, 0, 0);

    // Single-cycle lock glitch is ignored.
    pll_lock = 1'b0; tick(1); pll_lock = 1'b1;
    step("glitch_1cyc", 5, 1, 0, 1, 0, 0, 0);

    // Three-cycle drop: loss after the second low sample, then re-acquire.
    pll_lock = 1'b0;
    step("drop_pre", 3, 1, 0, 1, 0, 0, 0);
    pll_lock = 1'b1;
    step("loss_hold", 1, 0, 1, 0, 0, 0, 1);
    step("reacq_settle", 12, 1, 1, 0, 0, 0, 1);
    step("reacq_run", 1, 1, 0, 1, 0, 0, 1);

    // Lock drop on the fifth SETTLE cycle, then a full settle restart.
    enable = 1'b0; pll_lock = 1'b0;
    step("disable_idle", 1, 0, 1, 0, 0, 0, 1);
    enable = 1'b1;
    step("wait2", 5, 1, 1, 0, 0, 0, 1);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    step("settle_cyc4", 2, 1, 1, 0, 0, 0, 1);
    step("settle_fail", 1, 0, 1, 0, 0, 1, 1);
    pll_lock = 1'b1;
    step("restart_settle", 12, 1, 1, 0, 0, 1, 1);
    step("restart_run", 1, 1, 0, 1, 0, 0, 1);

    // Lock never arrives: three timeouts, then FAULT.
    enable = 1'b0; pll_lock = 1'b0;
    step("idle3", 1, 0, 1, 0, 0, 0, 1);
    enable = 1'b1;
    step("try1_wait", 5, 1, 1, 0, 0, 0, 1);
    step("try1_end", 19, 1, 1, 0, 0, 0, 1);
    step("try1_fail", 1, 0, 1, 0, 0, 1, 1);
    step("try2_wait", 4, 1, 1, 0, 0, 1, 1);
    step("try2_fail", 20, 0, 1, 0, 0, 2, 1);
    step("try3_end", 23, 1, 1, 0, 0, 2, 1);
    step("fault", 1, 0, 1, 0, 1, 3, 1);
    step("fault_stays", 3, 0, 1, 0, 1, 3, 1);

    // FAULT exit through ENABLE low then high.
    enable = 1'b0;
    step("fault_idle", 1, 0, 1, 0, 0, 0, 1);
    enable = 1'b1;
    step("fault_rehold", 4, 0, 1, 0, 0, 0, 1);
    step("fault_rewait", 1, 1, 1, 0, 0, 0, 1);

    // RESET in WAIT_LOCK with a non-zero retry count.
    step("pre_rst_fail", 20, 0, 1, 0, 0, 1, 1);
    step("pre_rst_wait", 4, 1, 1, 0, 0, 1, 1);
    reset = 1'b1;
    step("reset_mid", 1, 0, 1, 0, 0, 0, 0);
    reset = 1'b0;

    // 256 lock losses: the counter saturates at 255.
    pll_lock = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_ready("loss_loop");
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      exp_loss = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      step("loss_n", 1, 0, 1, 0, 0, 0, exp_loss);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles PLL_RESETB is held low per start attempt.
REQ-002 Parameter LOCK_TIMEOUT, default 12000: cycles allowed for lock after PLL_RESETB release (1 ms at 12 MHz).
REQ-003 Parameter SETTLE_CYCLES, default 1200: consecutive locked cycles required before the pixel domain is released.
REQ-004 Parameter MAX_RETRIES, default 4: failed attempts tolerated before FAULT.
REQ-005 CLK  input  1  12 MHz reference clock; the only clock.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 ENABLE  input  1  level; 1 = bring up and keep the PLL running.
REQ-008 PLL_LOCK  input  1  PLL lock flag; asynchronous to CLK.
REQ-009 PLL_RESETB  output  1  active-low reset driven to the PLL.
REQ-010 DOMAIN_RESET  output  1  active-high reset for the pixel-clock domain; the consumer synchronizes it.
REQ-011 READY  output  1  1 only in RUN.
REQ-012 FAULT  output  1  1 only in FAULT.
REQ-013 RETRY_COUNT  output  4  failed attempts since the last RUN entry.
REQ-014 LOSS_COUNT  output  8  lock losses in RUN since reset; saturates at 255.

Function
REQ-015 PLL_LOCK shall pass through a two-flop synchronizer to produce lock_s; all timing below is relative to lock_s.
REQ-016 FSM states: IDLE, HOLD, WAIT_LOCK, SETTLE, RUN, FAULT; all outputs registered.
REQ-017 IDLE: PLL_RESETB=0, DOMAIN_RESET=1; ENABLE=1 -> HOLD next cycle.
REQ-018 HOLD: PLL_RESETB=0 for exactly HOLD_CYCLES cycles, then -> WAIT_LOCK.
REQ-019 WAIT_LOCK: PLL_RESETB=1; lock_s=1 -> SETTLE; cycle counter reaching LOCK_TIMEOUT with lock_s=0 -> failure.
REQ-020 SETTLE: lock_s must stay 1 for SETTLE_CYCLES consecutive cycles -> RUN; any lock_s=0 -> failure.
REQ-021 Failure: RETRY_COUNT increments; if the new value equals MAX_RETRIES -> FAULT, else -> HOLD.
REQ-022 Entering RUN: RETRY_COUNT clears; DOMAIN_RESET deasserts and READY asserts on the first RUN cycle.
REQ-023 RUN: lock_s=0 on 2 consecutive cycles -> HOLD, LOSS_COUNT increments; a single-cycle drop is ignored.
REQ-024 Lock loss: DOMAIN_RESET=1 and READY=0 in the cycle after the second low sample.
REQ-025 FAULT: PLL_RESETB=0, DOMAIN_RESET=1; exited only via RESET or ENABLE=0.
REQ-026 ENABLE=0 in any state -> IDLE next cycle; RETRY_COUNT clears; LOSS_COUNT is kept.
REQ-027 DOMAIN_RESET shall be 1 in every state except RUN.
REQ-028 Counter widths shall be sized from the parameters; counters reset on every state entry.

Reset
REQ-029 RESET=1 -> IDLE, PLL_RESETB=0, DOMAIN_RESET=1, READY=0, FAULT=0, RETRY_COUNT=0, LOSS_COUNT=0, synchronizer flops cleared.
REQ-030 RESET asserted mid-sequence overrides every transition in the same cycle.

Structure
REQ-031 The state enumeration and default timing constants shall reside in the shared clock package for reuse by other PLL wrappers.
REQ-032 The two-flop synchronizer shall be a separate sub-module, sync_2ff.

Verification (HOLD_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=3)
REQ-033 ENABLE=1 and PLL_LOCK=1 ten cycles after PLL_RESETB rises -> READY=1 and DOMAIN_RESET=0 exactly 2+8 cycles after the lock_s path settles; RETRY_COUNT=0.
REQ-034 PLL_LOCK held at 0 -> three HOLD/WAIT_LOCK cycles of 4+20 cycles each, then FAULT=1, RETRY_COUNT=3, PLL_RESETB=0.
REQ-035 In RUN, PLL_LOCK low for 1 cycle -> READY stays 1; low for 3 cycles -> DOMAIN_RESET=1, LOSS_COUNT=1, re-acquisition via HOLD.
REQ-036 Lock drop at SETTLE cycle 5 -> RETRY_COUNT=1, return to HOLD, settle counter restarts from 0.
REQ-037 In FAULT, ENABLE=0 then 1 -> IDLE then HOLD; RETRY_COUNT=0.
REQ-038 RESET pulse during WAIT_LOCK -> next cycle all outputs at their reset values; 256 lock losses -> LOSS_COUNT=255.
